// File: rtl/me_best_mv_tracker.sv
// Running-minimum SAD tracker for motion estimation: two-stage min search over
// NUM_CAND-lane batches, BATCHES per block, emitting best SAD and (mv_x, mv_y).
module me_best_mv_tracker #(
  parameter int NUM_CAND = 16,
  parameter int SAD_W    = 14,
  parameter int BATCHES  = 16,
  parameter int SEARCH_W = 16,
  parameter int TIE_LAST = 0,
  localparam int POS_W   = $clog2(NUM_CAND * BATCHES),
  localparam int X_W     = $clog2(SEARCH_W),
  localparam int Y_RAW   = $clog2(NUM_CAND * BATCHES / SEARCH_W),
  localparam int Y_W     = (Y_RAW < 1) ? 1 : Y_RAW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_CAND*SAD_W-1:0] in_sad,
  input  logic                      abort,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [SAD_W-1:0]          res_sad,
  output logic [POS_W-1:0]          res_pos,
  output logic [X_W-1:0]            res_mv_x,
  output logic [Y_W-1:0]            res_mv_y
);

  localparam int LANE_W = $clog2(NUM_CAND);
  localparam int B_W    = $clog2(BATCHES);
  localparam int XS_W   = X_W + 1;
  localparam int STEP_X = NUM_CAND % SEARCH_W;
  localparam int STEP_Y = NUM_CAND / SEARCH_W;

  // Both ports are valid/ready: a transfer happens on a rising edge where valid
  // and ready are both high; a producer holds its payload stable until then.
  logic              accept;
  logic              batch_last;

  logic [B_W-1:0]    batch_q;
  logic [X_W-1:0]    base_x_q, base_x_d;
  logic [Y_W-1:0]    base_y_q, base_y_d;

  logic              s1_valid_q, s1_first_q, s1_last_q;
  logic [SAD_W-1:0]  s1_sad_q;
  logic [POS_W-1:0]  s1_pos_q;
  logic [X_W-1:0]    s1_x_q, s1_x_d;
  logic [Y_W-1:0]    s1_y_q, s1_y_d;

  logic              rm_valid_q;
  logic [SAD_W-1:0]  rm_sad_q;
  logic [POS_W-1:0]  rm_pos_q;
  logic [X_W-1:0]    rm_x_q;
  logic [Y_W-1:0]    rm_y_q;

  logic              res_valid_q;
  logic [SAD_W-1:0]  res_sad_q;
  logic [POS_W-1:0]  res_pos_q;
  logic [X_W-1:0]    res_x_q;
  logic [Y_W-1:0]    res_y_q;

  logic [SAD_W-1:0]  lane_sad, cur_sad;
  logic [LANE_W-1:0] lane_idx;
  logic [XS_W-1:0]   lane_x, xs, bx;
  logic [Y_W-1:0]    lane_y;

  logic              take_new;
  logic [SAD_W-1:0]  win_sad;
  logic [POS_W-1:0]  win_pos;
  logic [X_W-1:0]    win_x;
  logic [Y_W-1:0]    win_y;

  assign in_ready   = !(res_valid_q && !res_ready);
  assign accept     = in_valid && in_ready && !abort;
  assign batch_last = (batch_q == B_W'(BATCHES - 1));

  // Lane minimum; per-lane mod/div by SEARCH_W fold to constants when unrolled.
  always_comb begin
    lane_sad = in_sad[SAD_W-1:0];
    lane_idx = '0;
    lane_x   = '0;
    lane_y   = '0;
    cur_sad  = '0;
    for (int i = 1; i < NUM_CAND; i++) begin
      cur_sad = in_sad[i*SAD_W +: SAD_W];
      if ((TIE_LAST != 0) ? (cur_sad <= lane_sad) : (cur_sad < lane_sad)) begin
        lane_sad = cur_sad;
        lane_idx = LANE_W'(i);
        lane_x   = XS_W'(i % SEARCH_W);
        lane_y   = Y_W'(i / SEARCH_W);
      end
    end
  end

  // Batch base coordinates advance by NUM_CAND positions with one wrap step.
  always_comb begin
    xs = {1'b0, base_x_q} + lane_x;
    if (xs >= XS_W'(SEARCH_W)) begin
      s1_x_d = X_W'(xs - XS_W'(SEARCH_W));
      s1_y_d = base_y_q + lane_y + Y_W'(1);
    end else begin
      s1_x_d = X_W'(xs);
      s1_y_d = base_y_q + lane_y;
    end
    bx = {1'b0, base_x_q} + XS_W'(STEP_X);
    if (bx >= XS_W'(SEARCH_W)) begin
      base_x_d = X_W'(bx - XS_W'(SEARCH_W));
      base_y_d = base_y_q + Y_W'(STEP_Y) + Y_W'(1);
    end else begin
      base_x_d = X_W'(bx);
      base_y_d = base_y_q + Y_W'(STEP_Y);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      batch_q    <= '0;
      base_x_q   <= '0;
      base_y_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_sad_q   <= '0;
      s1_pos_q   <= '0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
    end else if (abort) begin
      batch_q    <= '0;
      base_x_q   <= '0;
      base_y_q   <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        batch_q    <= batch_last ? '0 : batch_q + B_W'(1);
        base_x_q   <= batch_last ? '0 : base_x_d;
        base_y_q   <= batch_last ? '0 : base_y_d;
        s1_first_q <= (batch_q == '0);
        s1_last_q  <= batch_last;
        s1_sad_q   <= lane_sad;
        s1_pos_q   <= {batch_q, lane_idx};
        s1_x_q     <= s1_x_d;
        s1_y_q     <= s1_y_d;
      end
    end
  end

  // Batch 0 (or an empty running min) always wins; afterwards the tie rule applies.
  always_comb begin
    take_new = s1_first_q || !rm_valid_q ||
               ((TIE_LAST != 0) ? (s1_sad_q <= rm_sad_q) : (s1_sad_q < rm_sad_q));
    win_sad  = take_new ? s1_sad_q : rm_sad_q;
    win_pos  = take_new ? s1_pos_q : rm_pos_q;
    win_x    = take_new ? s1_x_q   : rm_x_q;
    win_y    = take_new ? s1_y_q   : rm_y_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rm_valid_q  <= 1'b0;
      rm_sad_q    <= '0;
      rm_pos_q    <= '0;
      rm_x_q      <= '0;
      rm_y_q      <= '0;
      res_valid_q <= 1'b0;
      res_sad_q   <= '0;
      res_pos_q   <= '0;
      res_x_q     <= '0;
      res_y_q     <= '0;
    end else begin
      if (abort) begin
        rm_valid_q <= 1'b0;
      end else if (s1_valid_q) begin
        rm_valid_q <= !s1_last_q;
        rm_sad_q   <= win_sad;
        rm_pos_q   <= win_pos;
        rm_x_q     <= win_x;
        rm_y_q     <= win_y;
      end
      if (!abort && s1_valid_q && s1_last_q) begin
        res_valid_q <= 1'b1;
        res_sad_q   <= win_sad;
        res_pos_q   <= win_pos;
        res_x_q     <= win_x;
        res_y_q     <= win_y;
      end else if (res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign res_valid = res_valid_q;
  assign res_sad   = res_sad_q;
  assign res_pos   = res_pos_q;
  assign res_mv_x  = res_x_q;
  assign res_mv_y  = res_y_q;

endmodule

// File: tb/tb_me_best_mv_tracker.sv
// Bench for me_best_mv_tracker: two default instances (earliest/latest tie rule)
// sharing stimulus, plus a small-parameter instance.
module tb_me_best_mv_tracker;

  localparam int NC    = 16;
  localparam int SW    = 14;
  localparam int NB    = 16;
  localparam int SRW   = 16;
  localparam int NTOT  = NC * NB;
  localparam int POS_W = 8;
  localparam int X_W   = 4;
  localparam int Y_W   = 4;
  localparam int ENT_W = SW + POS_W;

  localparam int NC2    = 4;
  localparam int NB2    = 8;
  localparam int SRW2   = 8;
  localparam int NTOT2  = NC2 * NB2;
  localparam int POS_W2 = 5;
  localparam int X_W2   = 3;
  localparam int Y_W2   = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0;
  logic             abort = 1'b0;
  logic [NC*SW-1:0] in_sad = '0;
  logic             rdy_manual = 1'b1;
  logic             rand_rdy_en = 1'b0;
  logic             rand_rdy = 1'b1;
  logic             res_ready;
  assign res_ready = rand_rdy_en ? rand_rdy : rdy_manual;

  logic             in_ready_e, res_valid_e, in_ready_l, res_valid_l;
  logic [SW-1:0]    res_sad_e, res_sad_l;
  logic [POS_W-1:0] res_pos_e, res_pos_l;
  logic [X_W-1:0]   res_x_e, res_x_l;
  logic [Y_W-1:0]   res_y_e, res_y_l;

  logic              s_in_valid = 1'b0;
  logic [NC2*SW-1:0] s_in_sad = '0;
  logic              s_abort = 1'b0;
  logic              s_res_ready = 1'b1;
  logic              s_in_ready, s_res_valid;
  logic [SW-1:0]     s_res_sad;
  logic [POS_W2-1:0] s_res_pos;
  logic [X_W2-1:0]   s_res_x;
  logic [Y_W2-1:0]   s_res_y;

  me_best_mv_tracker #(.NUM_CAND(NC), .SAD_W(SW), .BATCHES(NB), .SEARCH_W(SRW), .TIE_LAST(0)) dut_e (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_e), .in_sad(in_sad),
    .abort(abort), .res_valid(res_valid_e), .res_ready(res_ready), .res_sad(res_sad_e),
    .res_pos(res_pos_e), .res_mv_x(res_x_e), .res_mv_y(res_y_e));

  me_best_mv_tracker #(.NUM_CAND(NC), .SAD_W(SW), .BATCHES(NB), .SEARCH_W(SRW), .TIE_LAST(1)) dut_l (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l), .in_sad(in_sad),
    .abort(abort), .res_valid(res_valid_l), .res_ready(res_ready), .res_sad(res_sad_l),
    .res_pos(res_pos_l), .res_mv_x(res_x_l), .res_mv_y(res_y_l));

  me_best_mv_tracker #(.NUM_CAND(NC2), .SAD_W(SW), .BATCHES(NB2), .SEARCH_W(SRW2), .TIE_LAST(0)) dut_s (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_sad(s_in_sad),
    .abort(s_abort), .res_valid(s_res_valid), .res_ready(s_res_ready), .res_sad(s_res_sad),
    .res_pos(s_res_pos), .res_mv_x(s_res_x), .res_mv_y(s_res_y));

  int n_checks = 0;
  int n_fail = 0;
  int unsigned blk[NTOT];
  int unsigned blk2[NTOT2];
  logic [ENT_W-1:0] exp_e_q[$];
  logic [ENT_W-1:0] exp_l_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      $error("assertion %s", tag);
    end
  endtask

  // reference model: linear scan over block positions
  task automatic model_push();
    int be = 0;
    int bl = 0;
    for (int p = 1; p < NTOT; p++) begin
      if (blk[p] < blk[be]) be = p;
      if (blk[p] <= blk[bl]) bl = p;
    end
    exp_e_q.push_back({POS_W'(be), SW'(blk[be])});
    exp_l_q.push_back({POS_W'(bl), SW'(blk[bl])});
  endtask

  task automatic fill_const(input int unsigned v);
    for (int p = 0; p < NTOT; p++) blk[p] = v;
  endtask

  task automatic fill_rand(input int unsigned lo, input int unsigned hi);
    for (int p = 0; p < NTOT; p++) blk[p] = $urandom_range(hi, lo);
  endtask

  task automatic load_batch(input int b);
    for (int l = 0; l < NC; l++) in_sad[l*SW +: SW] = SW'(blk[b*NC+l]);
  endtask

  // driver: called at a negedge, returns at the negedge after the accept edge
  task automatic send_batch(input int b);
    int waitc = 0;
    load_batch(b);
    in_valid = 1'b1;
    #1;
    while (!in_ready_e && waitc < 200) begin
      @(negedge clk);
      #1;
      waitc++;
    end
    check("accept_wait_bound", 64'(waitc < 200), 64'(1));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_block(input bit gaps);
    for (int b = 0; b < NB; b++) begin
      if (gaps && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      send_batch(b);
    end
  endtask

  task automatic score(input string tag, input logic [SW-1:0] sad, input logic [POS_W-1:0] pos,
                       input logic [X_W-1:0] x, input logic [Y_W-1:0] y, input logic [ENT_W-1:0] ent);
    logic [POS_W-1:0] ep;
    ep = ent[ENT_W-1:SW];
    check({tag, "_sad"}, 64'(sad), 64'(ent[SW-1:0]));
    check({tag, "_pos"}, 64'(pos), 64'(ep));
    check({tag, "_mv_x"}, 64'(x), 64'(ep % SRW));
    check({tag, "_mv_y"}, 64'(y), 64'(ep / SRW));
  endtask

  always @(posedge clk) begin
    #2;
    rand_rdy = ($urandom_range(0, 3) != 0);
  end

  // scoreboards: every consumed result must match the head of the expected queue
  always @(negedge clk) begin
    logic [ENT_W-1:0] ent;
    #2;
    if (!rst && res_valid_e && res_ready) begin
      check("sb_e_pending", 64'(exp_e_q.size() != 0), 64'(1));
      if (exp_e_q.size() != 0) begin
        ent = exp_e_q.pop_front();
        score("sb_e", res_sad_e, res_pos_e, res_x_e, res_y_e, ent);
      end
    end
    if (!rst && res_valid_l && res_ready) begin
      check("sb_l_pending", 64'(exp_l_q.size() != 0), 64'(1));
      if (exp_l_q.size() != 0) begin
        ent = exp_l_q.pop_front();
        score("sb_l", res_sad_l, res_pos_l, res_x_l, res_y_l, ent);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ENT_W-1:0] a_ent;
    int w;
    int best;

    #12;
    check("rst_res_valid", 64'(res_valid_e), 64'(0));
    check("rst_res_sad", 64'(res_sad_e), 64'(0));
    check("rst_res_pos", 64'(res_pos_e), 64'(0));
    check("rst_mv_x", 64'(res_x_e), 64'(0));
    check("rst_mv_y", 64'(res_y_e), 64'(0));
    check("rst_in_ready", 64'(in_ready_e), 64'(1));
    check("rst_s_res_valid", 64'(s_res_valid), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // single unique minimum
    fill_const(1000);
    blk[5*NC+9] = 37;
    model_push();
    send_block(1'b0);
    check("t1_not_early", 64'(res_valid_e), 64'(0));
    @(negedge clk);
    check("t1_valid", 64'(res_valid_e), 64'(1));
    check("t1_sad", 64'(res_sad_e), 64'(37));
    check("t1_pos", 64'(res_pos_e), 64'(89));
    check("t1_mv_x", 64'(res_x_e), 64'(9));
    check("t1_mv_y", 64'(res_y_e), 64'(5));

    // ties across batches
    fill_const(900);
    blk[2*NC+3] = 50;
    blk[11*NC+0] = 50;
    model_push();
    send_block(1'b0);
    @(negedge clk);
    check("tie_e_sad", 64'(res_sad_e), 64'(50));
    check("tie_e_pos", 64'(res_pos_e), 64'(35));
    check("tie_e_mv_x", 64'(res_x_e), 64'(3));
    check("tie_e_mv_y", 64'(res_y_e), 64'(2));
    check("tie_l_pos", 64'(res_pos_l), 64'(176));
    check("tie_l_mv_x", 64'(res_x_l), 64'(0));
    check("tie_l_mv_y", 64'(res_y_l), 64'(11));

    // abort on the accept of batch 7
    fill_rand(100, 900);
    for (int b = 0; b < 7; b++) send_batch(b);
    load_batch(7);
    in_valid = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort7_no_result", 64'(res_valid_e), 64'(0));

    // abort while the last batch sits in stage 1
    fill_rand(100, 900);
    send_block(1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_last_no_result", 64'(res_valid_e), 64'(0));
    check("abort_last_no_result_l", 64'(res_valid_l), 64'(0));

    fill_rand(100, 900);
    blk[0] = 3;
    model_push();
    send_block(1'b0);
    @(negedge clk);
    check("post_abort_sad", 64'(res_sad_e), 64'(3));
    check("post_abort_pos", 64'(res_pos_e), 64'(0));

    // random blocks with idle gaps and random result backpressure
    rand_rdy_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) fill_rand(0, 15);
      else fill_rand(0, 16383);
      model_push();
      send_block(1'b1);
    end
    w = 0;
    while ((exp_e_q.size() != 0 || exp_l_q.size() != 0) && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("rand_drain_bound", 64'(w < 100), 64'(1));
    rand_rdy_en = 1'b0;
    rdy_manual = 1'b0;
    repeat (2) @(negedge clk);

    // backpressure: result held, batch 0 of the next block already taken
    fill_rand(10, 500);
    model_push();
    a_ent = exp_e_q[exp_e_q.size()-1];
    send_block(1'b0);
    fill_rand(10, 500);
    blk[5] = 1;
    model_push();
    load_batch(0);
    in_valid = 1'b1;
    @(negedge clk);
    check("bp_valid", 64'(res_valid_e), 64'(1));
    check("bp_in_ready_low", 64'(in_ready_e), 64'(0));
    check("bp_sad", 64'(res_sad_e), 64'(a_ent[SW-1:0]));
    check("bp_pos", 64'(res_pos_e), 64'(a_ent[ENT_W-1:SW]));
    load_batch(1);
    repeat (4) begin
      @(negedge clk);
      check("bp_hold_valid", 64'(res_valid_e), 64'(1));
      check("bp_hold_sad", 64'(res_sad_e), 64'(a_ent[SW-1:0]));
      check("bp_hold_pos", 64'(res_pos_e), 64'(a_ent[ENT_W-1:SW]));
      check("bp_hold_in_ready", 64'(in_ready_e), 64'(0));
    end
    rdy_manual = 1'b1;
    #1;
    check("bp_ready_same_cycle", 64'(in_ready_e), 64'(1));
    for (int b = 1; b < NB; b++) send_batch(b);
    @(negedge clk);
    check("bp_b_valid", 64'(res_valid_e), 64'(1));
    check("bp_b_sad", 64'(res_sad_e), 64'(1));
    check("bp_b_pos", 64'(res_pos_e), 64'(5));

    // async reset in the middle of a block
    fill_rand(100, 900);
    for (int b = 0; b < 10; b++) send_batch(b);
    load_batch(10);
    in_valid = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_res_valid", 64'(res_valid_e), 64'(0));
    check("mid_rst_res_sad", 64'(res_sad_e), 64'(0));
    check("mid_rst_res_pos", 64'(res_pos_e), 64'(0));
    check("mid_rst_mv_x", 64'(res_x_e), 64'(0));
    check("mid_rst_mv_y", 64'(res_y_e), 64'(0));
    check("mid_rst_in_ready", 64'(in_ready_e), 64'(1));
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    fill_rand(200, 3000);
    blk[NTOT-1] = 5;
    model_push();
    send_block(1'b0);
    @(negedge clk);
    check("post_rst_sad", 64'(res_sad_e), 64'(5));
    check("post_rst_pos", 64'(res_pos_e), 64'(255));
    check("post_rst_mv_x", 64'(res_x_e), 64'(15));
    check("post_rst_mv_y", 64'(res_y_e), 64'(15));
    repeat (3) @(negedge clk);
    check("final_queue_e_empty", 64'(exp_e_q.size()), 64'(0));
    check("final_queue_l_empty", 64'(exp_l_q.size()), 64'(0));

    // small configuration: 4 lanes, 8 batches, 8-wide window
    for (int p = 0; p < NTOT2; p++) blk2[p] = 500;
    blk2[3*NC2+2] = 9;
    for (int b = 0; b < NB2; b++) begin
      for (int l = 0; l < NC2; l++) s_in_sad[l*SW +: SW] = SW'(blk2[b*NC2+l]);
      s_in_valid = 1'b1;
      @(negedge clk);
    end
    s_in_valid = 1'b0;
    check("small_not_early", 64'(s_res_valid), 64'(0));
    @(negedge clk);
    check("small_valid", 64'(s_res_valid), 64'(1));
    check("small_sad", 64'(s_res_sad), 64'(9));
    check("small_pos", 64'(s_res_pos), 64'(14));
    check("small_mv_x", 64'(s_res_x), 64'(6));
    check("small_mv_y", 64'(s_res_y), 64'(1));

    for (int p = 0; p < NTOT2; p++) blk2[p] = $urandom_range(40, 0);
    best = 0;
    for (int p = 1; p < NTOT2; p++) if (blk2[p] < blk2[best]) best = p;
    for (int b = 0; b < NB2; b++) begin
      for (int l = 0; l < NC2; l++) s_in_sad[l*SW +: SW] = SW'(blk2[b*NC2+l]);
      s_in_valid = 1'b1;
      @(negedge clk);
    end
    s_in_valid = 1'b0;
    @(negedge clk);
    check("small_rand_valid", 64'(s_res_valid), 64'(1));
    check("small_rand_sad", 64'(s_res_sad), 64'(blk2[best]));
    check("small_rand_pos", 64'(s_res_pos), 64'(best));
    check("small_rand_mv_x", 64'(s_res_x), 64'(best % SRW2));
    check("small_rand_mv_y", 64'(s_res_y), 64'(best / SRW2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
